slink_axi_outstanding_limiter: RTL
==================================

SLINK_AXI_OUTSTANDING_LIMITER -- requirements
Module: slink_axi_outstanding_limiter

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32: AW/AR address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64: W/R data width.
REQ-003 SHALL have parameter MAX_WR_OUTSTANDING, default 8, range 1-255: write bursts allowed in flight.
REQ-004 SHALL have parameter MAX_RD_OUTSTANDING, default 8, range 1-255: read bursts allowed in flight.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16'hFFFF: response watchdog limit.
REQ-006 SHALL have port axi_clk, input, 1: the single clock; all logic is synchronous to it.
REQ-007 SHALL have port axi_reset, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port enable, input, 1: 1 = admit new traffic; 0 = drain.
REQ-009 SHALL have ports s_aw*/s_w*/s_b*/s_ar*/s_r*, AXI widths: upstream master side.
REQ-010 SHALL have ports m_aw*/m_w*/m_b*/m_ar*/m_r*, AXI widths: downstream side, connects to the S-Link AXI target tgt_* ports.
REQ-011 SHALL have port idle, output, 1: high in state IDLE.
REQ-012 SHALL have port proto_err, output, 1: sticky protocol error.
REQ-013 SHALL have port timeout_err, output, 1: sticky response timeout.

Function
REQ-014 SHALL pass all payload fields (id, addr, len, size, burst, lock, cache, prot, qos, region, data, strb, last, resp) combinationally, zero latency.
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN:
- IDLE->RUN when enable=1.
- RUN->DRAIN when enable=0.
- DRAIN->IDLE when wr_cnt=0, rd_cnt=0 and wpend=0.
- DRAIN SHALL NOT return directly to RUN.
REQ-016 SHALL keep wr_cnt: +1 on m_aw handshake, -1 on s_b handshake, unchanged when both occur in one cycle.
REQ-017 SHALL keep rd_cnt: +1 on m_ar handshake, -1 on s_r handshake with rlast=1, unchanged when both occur in one cycle.
REQ-018 SHALL keep wpend: +1 on m_aw handshake, -1 on m_w handshake with wlast=1, unchanged when both occur in one cycle.
REQ-019 SHALL make counters clog2(MAX+1) bits wide; they SHALL never wrap.
REQ-020 SHALL gate AW: m_awvalid = s_awvalid & RUN & (wr_cnt<MAX_WR_OUTSTANDING); s_awready = m_awready & the same gate.
REQ-021 SHALL gate AR the same way using rd_cnt and MAX_RD_OUTSTANDING.
REQ-022 SHALL gate W: m_wvalid = s_wvalid & (wpend>0); s_wready = m_wready & (wpend>0). Consequences:
- W never precedes its AW.
- W is allowed in DRAIN.
REQ-023 SHALL pass B and R unconditionally in every state.
REQ-024 SHALL handle a decrement at count 0 as follows: count held at 0, proto_err set; applies to B, R-last or W-last.
REQ-025 SHALL keep gating decisions combinational from current registered counts; a burst admitted at count MAX-1 blocks the next burst from the following cycle.

Reset
REQ-026 SHALL, on axi_reset=1 at a clock edge, force: state=IDLE; wr_cnt, rd_cnt, wpend, watchdog = 0; proto_err, timeout_err = 0.
REQ-027 SHALL drive during reset: m_awvalid=m_arvalid=m_wvalid=0; s_awready=s_arready=s_wready=0; idle=1.
REQ-028 SHALL NOT track bursts in flight across a reset asserted mid-operation; responses arriving later set proto_err.

Configuration
REQ-029 SHALL, with macro SLINK_AXI_LIMITER_TIMEOUT_EN defined, run a 16-bit watchdog:
- Counts while (wr_cnt+rd_cnt)>0 and no s_b/s_r handshake occurs.
- Clears on any such handshake or when the counts are zero.
- Sets timeout_err and saturates on reaching TIMEOUT_CYCLES.
REQ-030 SHALL, without the macro, remove the watchdog logic and tie timeout_err to 0.

Verification
REQ-031 SHALL cover: MAX_WR=2, three back-to-back AWs, B withheld -> 2 accepted, third s_awready=0 until first B, then accepted next cycle.
REQ-032 SHALL cover: W presented before AW -> s_wready=0; AW accepted -> W accepted from next cycle; wpend back to 0 after wlast.
REQ-033 SHALL cover: enable dropped with 1 write and 1 read outstanding -> DRAIN; AW/AR blocked; idle=1 one cycle after final B and R-last.
REQ-034 SHALL cover: AW handshake and B handshake in same cycle at wr_cnt=1 -> wr_cnt stays 1.
REQ-035 SHALL cover: s_bvalid&s_bready at wr_cnt=0 -> proto_err=1 and stays set until reset.
REQ-036 SHALL cover: macro defined, TIMEOUT_CYCLES=16, one read outstanding, no R -> timeout_err=1 after 16 cycles; macro undefined -> timeout_err stays 0.

Source files
------------

// File: rtl/slink_axi_outstanding_limiter.sv
// slink_axi_outstanding_limiter
// Sits between an AXI master and the S-Link AXI target. It caps the number of
// write and read bursts in flight, holds W beats until their AW has gone out,
// and drains cleanly when enable drops. Payload passes through with no latency.
// Optional response watchdog: define SLINK_AXI_LIMITER_TIMEOUT_EN.
module slink_axi_outstanding_limiter #(
    parameter int              AXI_ADDR_WIDTH     = 32,
    parameter int              AXI_DATA_WIDTH     = 64,
    parameter int              AXI_ID_WIDTH       = 4,
    parameter int              MAX_WR_OUTSTANDING = 8,
    parameter int              MAX_RD_OUTSTANDING = 8,
    parameter logic [15:0]     TIMEOUT_CYCLES     = 16'hFFFF
) (
    input  logic                        axi_clk,
    input  logic                        axi_reset,
    input  logic                        enable,
    // upstream AW
    input  logic [AXI_ID_WIDTH-1:0]     s_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]                  s_awlen,
    input  logic [2:0]                  s_awsize,
    input  logic [1:0]                  s_awburst,
    input  logic                        s_awlock,
    input  logic [3:0]                  s_awcache,
    input  logic [2:0]                  s_awprot,
    input  logic [3:0]                  s_awqos,
    input  logic [3:0]                  s_awregion,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    // upstream W
    input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                        s_wlast,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    // upstream B
    output logic [AXI_ID_WIDTH-1:0]     s_bid,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    // upstream AR
    input  logic [AXI_ID_WIDTH-1:0]     s_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]                  s_arlen,
    input  logic [2:0]                  s_arsize,
    input  logic [1:0]                  s_arburst,
    input  logic                        s_arlock,
    input  logic [3:0]                  s_arcache,
    input  logic [2:0]                  s_arprot,
    input  logic [3:0]                  s_arqos,
    input  logic [3:0]                  s_arregion,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    // upstream R
    output logic [AXI_ID_WIDTH-1:0]     s_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rlast,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    // downstream AW
    output logic [AXI_ID_WIDTH-1:0]     m_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]                  m_awlen,
    output logic [2:0]                  m_awsize,
    output logic [1:0]                  m_awburst,
    output logic                        m_awlock,
    output logic [3:0]                  m_awcache,
    output logic [2:0]                  m_awprot,
    output logic [3:0]                  m_awqos,
    output logic [3:0]                  m_awregion,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    // downstream W
    output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
    output logic                        m_wlast,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    // downstream B
    input  logic [AXI_ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]                  m_bresp,
    input  logic                        m_bvalid,
    output logic                        m_bready,
    // downstream AR
    output logic [AXI_ID_WIDTH-1:0]     m_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]                  m_arlen,
    output logic [2:0]                  m_arsize,
    output logic [1:0]                  m_arburst,
    output logic                        m_arlock,
    output logic [3:0]                  m_arcache,
    output logic [2:0]                  m_arprot,
    output logic [3:0]                  m_arqos,
    output logic [3:0]                  m_arregion,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    // downstream R
    input  logic [AXI_ID_WIDTH-1:0]     m_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]                  m_rresp,
    input  logic                        m_rlast,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    // status
    output logic                        idle,
    output logic                        proto_err,
    output logic                        timeout_err
);

    localparam int WC_W = $clog2(MAX_WR_OUTSTANDING + 1);
    localparam int RC_W = $clog2(MAX_RD_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    logic            idle_q;
    logic [WC_W-1:0] wr_cnt;
    logic [RC_W-1:0] rd_cnt;
    logic [WC_W-1:0] wpend;

    // Gates use only registered counts, so a burst admitted at MAX-1 blocks
    // the next one from the following cycle. Reset closes every gate at once.
    logic aw_ok, ar_ok, w_ok;
    assign aw_ok = (state == RUN) && !axi_reset && (wr_cnt < WC_W'(MAX_WR_OUTSTANDING));
    assign ar_ok = (state == RUN) && !axi_reset && (rd_cnt < RC_W'(MAX_RD_OUTSTANDING));
    assign w_ok  = (wpend != '0) && !axi_reset;

    assign m_awvalid = s_awvalid & aw_ok;
    assign s_awready = m_awready & aw_ok;
    assign m_arvalid = s_arvalid & ar_ok;
    assign s_arready = m_arready & ar_ok;
    assign m_wvalid  = s_wvalid & w_ok;
    assign s_wready  = m_wready & w_ok;

    // Responses are never held back, whatever the state.
    assign s_bvalid = m_bvalid;
    assign m_bready = s_bready;
    assign s_rvalid = m_rvalid;
    assign m_rready = s_rready;

    assign m_awid = s_awid;     assign m_awaddr  = s_awaddr;  assign m_awlen   = s_awlen;
    assign m_awsize = s_awsize; assign m_awburst = s_awburst; assign m_awlock  = s_awlock;
    assign m_awcache = s_awcache; assign m_awprot = s_awprot; assign m_awqos   = s_awqos;
    assign m_awregion = s_awregion;
    assign m_arid = s_arid;     assign m_araddr  = s_araddr;  assign m_arlen   = s_arlen;
    assign m_arsize = s_arsize; assign m_arburst = s_arburst; assign m_arlock  = s_arlock;
    assign m_arcache = s_arcache; assign m_arprot = s_arprot; assign m_arqos   = s_arqos;
    assign m_arregion = s_arregion;
    assign m_wdata = s_wdata;   assign m_wstrb   = s_wstrb;   assign m_wlast   = s_wlast;
    assign s_bid   = m_bid;     assign s_bresp   = m_bresp;
    assign s_rid   = m_rid;     assign s_rdata   = m_rdata;   assign s_rresp   = m_rresp;
    assign s_rlast = m_rlast;

    logic aw_hs, ar_hs, wl_hs, b_hs, rl_hs, r_hs, underflow;
    assign aw_hs = m_awvalid & m_awready;
    assign ar_hs = m_arvalid & m_arready;
    assign wl_hs = m_wvalid & m_wready & s_wlast;
    assign b_hs  = s_bvalid & s_bready;
    assign r_hs  = s_rvalid & s_rready;
    assign rl_hs = r_hs & s_rlast;

    // A completion with nothing tracked is a protocol error (also covers
    // responses to bursts forgotten by a mid-flight reset).
    assign underflow = (b_hs  && !aw_hs && wr_cnt == '0) ||
                       (rl_hs && !ar_hs && rd_cnt == '0) ||
                       (wl_hs && !aw_hs && wpend  == '0);

    assign idle = idle_q | axi_reset;

    // Mode FSM; idle is registered alongside the state.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state  <= IDLE;
            idle_q <= 1'b1;
        end else begin
            case (state)
                IDLE:    if (enable) begin state <= RUN; idle_q <= 1'b0; end
                RUN:     if (!enable) state <= DRAIN;
                DRAIN:   if (wr_cnt == '0 && rd_cnt == '0 && wpend == '0) begin
                             state  <= IDLE;
                             idle_q <= 1'b1;
                         end
                default: begin state <= IDLE; idle_q <= 1'b1; end
            endcase
        end
    end

    // In-flight counters: simultaneous inc/dec cancel, underflow holds at 0.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wpend     <= '0;
            proto_err <= 1'b0;
        end else begin
            if (aw_hs && !b_hs)
                wr_cnt <= wr_cnt + 1'b1;
            else if (!aw_hs && b_hs && wr_cnt != '0)
                wr_cnt <= wr_cnt - 1'b1;

            if (ar_hs && !rl_hs)
                rd_cnt <= rd_cnt + 1'b1;
            else if (!ar_hs && rl_hs && rd_cnt != '0)
                rd_cnt <= rd_cnt - 1'b1;

            // wpend can outgrow wr_cnt if B overtakes W, so saturate it
            if (aw_hs && !wl_hs && wpend != '1)
                wpend <= wpend + 1'b1;
            else if (!aw_hs && wl_hs && wpend != '0)
                wpend <= wpend - 1'b1;

            if (underflow)
                proto_err <= 1'b1;
        end
    end

`ifdef SLINK_AXI_LIMITER_TIMEOUT_EN
    logic [15:0] wdog;

    // Watchdog: counts response-free cycles while anything is outstanding.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else if ((wr_cnt == '0 && rd_cnt == '0) || b_hs || r_hs) begin
            wdog <= '0;
        end else if (wdog != TIMEOUT_CYCLES) begin
            wdog <= wdog + 16'd1;
            if (wdog + 16'd1 == TIMEOUT_CYCLES)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
